// File: rtl/register_file.sv
// Architectural register file: one write port, two registered read ports with
// write-to-read bypass, and a busy scoreboard that stalls reads of reserved registers.

module register_file_rd_port #(
    parameter int regsize  = 16,
    parameter int nregs    = 8,
    parameter int addrsize = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            rd_en,
    input  logic [addrsize-1:0]             rd_addr,
    input  logic                            wr,
    input  logic [addrsize-1:0]             wr_addr,
    input  logic [regsize-1:0]              wr_data,
    input  logic [nregs-1:0][regsize-1:0]   regs,
    input  logic [nregs-1:0]                busy,
    output logic [regsize-1:0]              rd_data,
    output logic                            rd_valid,
    output logic                            rd_stall
);
    logic hit_wr;
    assign hit_wr = wr && (wr_addr == rd_addr);

    // busy is the pre-edge value, so a same-edge reservation never affects this read
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rd_stall <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            rd_stall <= 1'b0;
            if (rd_en) begin
                if (rd_addr == '0) begin
                    rd_data  <= '0;
                    rd_valid <= 1'b1;
                end else if (hit_wr) begin
                    rd_data  <= wr_data;
                    rd_valid <= 1'b1;
                end else if (busy[rd_addr]) begin
                    rd_stall <= 1'b1;
                end else begin
                    rd_data  <= regs[rd_addr];
                    rd_valid <= 1'b1;
                end
            end
        end
    end
endmodule

module register_file #(
    parameter int regsize  = 16,
    parameter int nregs    = 8,
    parameter int addrsize = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr,
    input  logic [addrsize-1:0] wr_addr,
    input  logic [regsize-1:0]  wr_data,
    input  logic                rsv,
    input  logic [addrsize-1:0] rsv_addr,
    input  logic                rd_en_a,
    input  logic [addrsize-1:0] rd_addr_a,
    output logic [regsize-1:0]  rd_data_a,
    output logic                rd_valid_a,
    output logic                rd_stall_a,
    input  logic                rd_en_b,
    input  logic [addrsize-1:0] rd_addr_b,
    output logic [regsize-1:0]  rd_data_b,
    output logic                rd_valid_b,
    output logic                rd_stall_b
);
    localparam int NUM_PORTS = 2;

    logic [nregs-1:0][regsize-1:0]     regs;
    logic [nregs-1:0]                  busy;
    logic [NUM_PORTS-1:0]              rd_en;
    logic [NUM_PORTS-1:0][addrsize-1:0] rd_addr;
    logic [NUM_PORTS-1:0][regsize-1:0] rd_data;
    logic [NUM_PORTS-1:0]              rd_valid;
    logic [NUM_PORTS-1:0]              rd_stall;

    // Register 0 is never written or reserved, so it stays at its reset value of 0.
    // The reserve update comes last so it wins over a same-edge write's busy clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs <= '0;
            busy <= '0;
        end else begin
            if (wr && (wr_addr != '0)) begin
                regs[wr_addr] <= wr_data;
                busy[wr_addr] <= 1'b0;
            end
            if (rsv && (rsv_addr != '0))
                busy[rsv_addr] <= 1'b1;
        end
    end

    assign rd_en   = {rd_en_b, rd_en_a};
    assign rd_addr = {rd_addr_b, rd_addr_a};

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        register_file_rd_port #(
            .regsize (regsize),
            .nregs   (nregs),
            .addrsize(addrsize)
        ) u_port (
            .clk     (clk),
            .rst     (rst),
            .rd_en   (rd_en[p]),
            .rd_addr (rd_addr[p]),
            .wr      (wr),
            .wr_addr (wr_addr),
            .wr_data (wr_data),
            .regs    (regs),
            .busy    (busy),
            .rd_data (rd_data[p]),
            .rd_valid(rd_valid[p]),
            .rd_stall(rd_stall[p])
        );
    end

    assign rd_data_a  = rd_data[0];
    assign rd_valid_a = rd_valid[0];
    assign rd_stall_a = rd_stall[0];
    assign rd_data_b  = rd_data[1];
    assign rd_valid_b = rd_valid[1];
    assign rd_stall_b = rd_stall[1];
endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: directed test-plan sequence with literal expectations,
// then random traffic, all checked every cycle against a behavioural model.

module tb_register_file;
    localparam int RS = 16;
    localparam int NR = 8;
    localparam int AS = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr = 1'b0, rsv = 1'b0, rd_en_a = 1'b0, rd_en_b = 1'b0;
    logic [AS-1:0] wr_addr = '0, rsv_addr = '0, rd_addr_a = '0, rd_addr_b = '0;
    logic [RS-1:0] wr_data = '0;
    logic [RS-1:0] rd_data_a, rd_data_b;
    logic          rd_valid_a, rd_valid_b, rd_stall_a, rd_stall_b;

    int checks = 0;
    int errors = 0;

    register_file #(.regsize(RS), .nregs(NR), .addrsize(AS)) dut (
        .clk(clk), .rst(rst),
        .wr(wr), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv(rsv), .rsv_addr(rsv_addr),
        .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a),
        .rd_valid_a(rd_valid_a), .rd_stall_a(rd_stall_a),
        .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b),
        .rd_valid_b(rd_valid_b), .rd_stall_b(rd_stall_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: architectural state as plain arrays, outputs as per-port results.
    logic [RS-1:0] m_regs [NR];
    bit            m_busy [NR];
    logic [RS-1:0] m_data [2];
    bit            m_valid[2];
    bit            m_stall[2];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NR; i++) begin m_regs[i] = '0; m_busy[i] = 0; end
            for (int p = 0; p < 2; p++) begin m_data[p] = '0; m_valid[p] = 0; m_stall[p] = 0; end
        end else begin
            for (int p = 0; p < 2; p++) begin
                bit en;
                int a;
                en = (p == 0) ? rd_en_a : rd_en_b;
                a  = (p == 0) ? int'(rd_addr_a) : int'(rd_addr_b);
                m_valid[p] = 0;
                m_stall[p] = 0;
                if (en) begin
                    if (a == 0)                          begin m_data[p] = '0;        m_valid[p] = 1; end
                    else if (wr && int'(wr_addr) == a)   begin m_data[p] = wr_data;   m_valid[p] = 1; end
                    else if (m_busy[a])                  m_stall[p] = 1;
                    else                                 begin m_data[p] = m_regs[a]; m_valid[p] = 1; end
                end
            end
            if (wr && wr_addr != 0) begin m_regs[wr_addr] = wr_data; m_busy[wr_addr] = 0; end
            if (rsv && rsv_addr != 0) m_busy[rsv_addr] = 1;
        end
    end

    always @(negedge clk) begin
        check("data_a",  32'(rd_data_a),  32'(m_data[0]));
        check("valid_a", 32'(rd_valid_a), 32'(m_valid[0]));
        check("stall_a", 32'(rd_stall_a), 32'(m_stall[0]));
        check("data_b",  32'(rd_data_b),  32'(m_data[1]));
        check("valid_b", 32'(rd_valid_b), 32'(m_valid[1]));
        check("stall_b", 32'(rd_stall_b), 32'(m_stall[1]));
    end

    task automatic idle();
        wr = 0; rsv = 0; rd_en_a = 0; rd_en_b = 0;
        wr_addr = '0; rsv_addr = '0; rd_addr_a = '0; rd_addr_b = '0; wr_data = '0;
    endtask

    // Inputs change only at negedge, so they are stable around every posedge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        #1 rst = 0;
        tick(); tick();
        @(negedge clk); rst = 1; #1;

        // reset then read
        idle(); rd_en_a = 1; rd_addr_a = 3'd5; tick();
        check("rst_rd_data",  32'(rd_data_a),  32'h0);
        check("rst_rd_valid", 32'(rd_valid_a), 32'h1);
        check("rst_rd_stall", 32'(rd_stall_a), 32'h0);

        // write then read
        idle(); wr = 1; wr_addr = 3'd3; wr_data = 16'h00A5; tick();
        idle(); rd_en_a = 1; rd_addr_a = 3'd3; tick();
        check("wr_rd_data",  32'(rd_data_a),  32'h00A5);
        check("wr_rd_valid", 32'(rd_valid_a), 32'h1);

        // bypass
        idle(); wr = 1; wr_addr = 3'd4; wr_data = 16'h1234; rd_en_b = 1; rd_addr_b = 3'd4; tick();
        check("byp_data_b",  32'(rd_data_b),  32'h1234);
        check("byp_valid_b", 32'(rd_valid_b), 32'h1);

        // scoreboard
        idle(); rsv = 1; rsv_addr = 3'd2; tick();
        idle(); rd_en_a = 1; rd_addr_a = 3'd2; tick();
        check("sb_stall",  32'(rd_stall_a), 32'h1);
        check("sb_valid0", 32'(rd_valid_a), 32'h0);
        check("sb_hold",   32'(rd_data_a),  32'h00A5);
        idle(); wr = 1; wr_addr = 3'd2; wr_data = 16'h0F0F; rd_en_a = 1; rd_addr_a = 3'd2; tick();
        check("sb_byp_valid", 32'(rd_valid_a), 32'h1);
        check("sb_byp_data",  32'(rd_data_a),  32'h0F0F);
        idle(); rd_en_a = 1; rd_addr_a = 3'd2; tick();
        check("sb_rel_stall", 32'(rd_stall_a), 32'h0);
        check("sb_rel_data",  32'(rd_data_a),  32'h0F0F);

        // same-edge write and reserve: reservation wins, data still written
        idle(); wr = 1; wr_addr = 3'd5; wr_data = 16'hBEEF; rsv = 1; rsv_addr = 3'd5; tick();
        idle(); rd_en_a = 1; rd_addr_a = 3'd5; tick();
        check("wrrsv_stall", 32'(rd_stall_a), 32'h1);
        idle(); wr = 1; wr_addr = 3'd7; wr_data = 16'h1111; rd_en_b = 1; rd_addr_b = 3'd5; tick();
        check("wrrsv_stall_b", 32'(rd_stall_b), 32'h1);

        // register 0 rules
        idle(); wr = 1; wr_addr = 3'd0; wr_data = 16'hFFFF; rsv = 1; rsv_addr = 3'd0; tick();
        idle(); rd_en_a = 1; rd_en_b = 1; tick();
        check("r0_data_a",  32'(rd_data_a),  32'h0);
        check("r0_valid_a", 32'(rd_valid_a), 32'h1);
        check("r0_stall_a", 32'(rd_stall_a), 32'h0);
        check("r0_data_b",  32'(rd_data_b),  32'h0);
        check("r0_valid_b", 32'(rd_valid_b), 32'h1);
        check("r0_stall_b", 32'(rd_stall_b), 32'h0);

        // async reset mid-operation
        for (int i = 1; i < NR; i++) begin
            idle(); wr = 1; wr_addr = AS'(i); wr_data = RS'(16'hA000 + i); tick();
        end
        idle(); rsv = 1; rsv_addr = 3'd6; rd_en_a = 1; rd_addr_a = 3'd1; rd_en_b = 1; rd_addr_b = 3'd7; tick();
        check("pre_rst_data_b", 32'(rd_data_b), 32'hA007);
        idle();
        #2 rst = 0;
        #1;
        check("arst_data_a",  32'(rd_data_a),  32'h0);
        check("arst_valid_b", 32'(rd_valid_b), 32'h0);
        check("arst_data_b",  32'(rd_data_b),  32'h0);
        @(negedge clk); rst = 1; #1;
        rd_en_a = 1; rd_addr_a = 3'd6; rd_en_b = 1; rd_addr_b = 3'd6; tick();
        check("post_rst_data",  32'(rd_data_a),  32'h0);
        check("post_rst_valid", 32'(rd_valid_a), 32'h1);
        check("post_rst_stall", 32'(rd_stall_b), 32'h0);

        // random traffic; reservations biased high so stalls are common
        for (int n = 0; n < 3000; n++) begin
            wr        = ($urandom_range(0, 2) != 0);
            wr_addr   = AS'($urandom_range(0, NR - 1));
            wr_data   = RS'($urandom);
            rsv       = ($urandom_range(0, 2) == 0);
            rsv_addr  = AS'($urandom_range(0, NR - 1));
            rd_en_a   = ($urandom_range(0, 3) != 0);
            rd_addr_a = AS'($urandom_range(0, NR - 1));
            rd_en_b   = ($urandom_range(0, 3) != 0);
            rd_addr_b = ($urandom_range(0, 3) == 0) ? rd_addr_a : AS'($urandom_range(0, NR - 1));
            if (n % 997 == 500) begin
                #2 rst = 0; #1 rst = 1;
            end
            tick();
        end

        idle(); tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- Multi-entry architectural register file for the custom RISC core.
- One write port (writer side) and two independent registered read ports (reader side), with write-to-read bypass.
- Holds a per-register busy scoreboard: the decode stage reserves a destination, and the writeback write releases it.
- Reads of a reserved register stall instead of returning stale data.

Parameters:
- regsize, `datasize, data width of each register.
- nregs, 8, number of registers (power of two, ≥2).
- addrsize, 3, address width; must equal log2(nregs).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- wr  in  1  write enable.
- wr_addr  in  addrsize  write register index.
- wr_data  in  regsize  write data.
- rsv  in  1  reserve request: mark rsv_addr busy.
- rsv_addr  in  addrsize  register to reserve.
- rd_en_a  in  1  read request, port A.
- rd_addr_a  in  addrsize  read index, port A.
- rd_data_a  out  regsize  registered read data, port A.
- rd_valid_a  out  1  one-cycle pulse: rd_data_a holds the requested value.
- rd_stall_a  out  1  one-cycle pulse: request refused, register busy.
- rd_en_b, rd_addr_b, rd_data_b, rd_valid_b, rd_stall_b: identical port B.

Behaviour:
- Reset (rst=0, asynchronous):
  - all registers = 0;
  - all busy bits = 0;
  - rd_data_a/b = 0;
  - rd_valid_a/b = 0;
  - rd_stall_a/b = 0.
  - Held state is released on the first edge after rst returns high.
- Register 0:
  - always reads 0;
  - writes to it are ignored;
  - never becomes busy (rsv to 0 is ignored).
- Write: on an edge with wr=1 and wr_addr≠0, regs[wr_addr] ← wr_data and busy[wr_addr] ← 0.
- Reserve: on an edge with rsv=1 and rsv_addr≠0, busy[rsv_addr] ← 1.
- Same-edge wr and rsv to the same nonzero address: the reservation wins (busy=1) and the data is still written. This models back-to-back producers.
- Read latency: 1 cycle. A request sampled at edge N gives outputs valid after edge N, for exactly one cycle.
- Per port, evaluated at the sampling edge with rd_en=1 and address R:
  - R=0: data=0, valid=1, stall=0.
  - busy[R]=1 and not (wr=1 and wr_addr=R): valid=0, stall=1, data holds its previous value.
  - wr=1 and wr_addr=R this edge: bypass, data=wr_data, valid=1. This applies even if R is busy, since the write clears it.
  - otherwise: data=regs[R], valid=1.
- A reservation on the same edge as a read does not affect that read; the busy state is sampled before the update.
- rd_en=0: valid=0, stall=0, data holds its previous value.
- Ports A and B are fully independent; both may read the same address in the same cycle.
- Width rules:
  - all addresses are unsigned;
  - no address wrap is needed, since addrsize exactly covers nregs;
  - data is stored unmodified, with no extension.

Test Plan:
- Reset then read: pulse rst low; rd_en_a=1, addr=5 → next cycle rd_data_a=0, rd_valid_a=1, rd_stall_a=0.
- Write then read:
  - wr=1, wr_addr=3, wr_data=0x00A5;
  - next cycle rd_en_a=1, addr=3 → rd_data_a=0x00A5, valid=1.
- Bypass: same cycle wr=1, addr=4, data=0x1234 and rd_en_b=1, addr=4 → rd_data_b=0x1234 after that edge.
- Scoreboard:
  - rsv=1, addr=2;
  - next cycle read A addr=2 → stall_a=1, valid_a=0;
  - then wr addr=2, data=0x0F0F with a read of 2 on the same edge → valid_a=1, data=0x0F0F;
  - subsequent read → no stall.
- R0 rules: wr addr=0, data=0xFFFF; rsv addr=0; then read 0 on both ports → both data=0, valid=1, no stall.
- Async reset mid-operation:
  - regs 1..7 written, reg 6 reserved;
  - drop rst mid-cycle → outputs clear immediately, without waiting for an edge;
  - after release, read 6 → data=0, valid=1, stall=0.
